p2p_link_arb: RTL and testbench



---
 rtl/p2p_link_arb.sv | 103 ++++++++++
 tb/tb_p2p_link_arb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/p2p_link_arb.sv
// Four-to-one round-robin link arbiter feeding a small tagged FIFO toward node A.
// Optional build macro LINK_PARITY_EN adds out_parity, stored per entry at push time.
module p2p_link_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*WIDTH-1:0]       in_data,
  input  logic [3:0]               in_valid,
  output logic [3:0]               in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [1:0]               out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef LINK_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef LINK_PARITY_EN
  localparam int EW = WIDTH + 3;
`else
  localparam int EW = WIDTH + 2;
`endif
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0][WIDTH-1:0] lane_data;
  logic [EW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [1:0]            rr, gnt_idx, idx;
  logic                  gnt_any, push, pop;
  logic [EW-1:0]         wr_entry, head;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      assign lane_data[g] = in_data[g*WIDTH +: WIDTH];
    end
  endgenerate

  // First requester at or after rr, wrapping naturally in 2 bits.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign out_valid = (count != '0);
  // Fullness alone blocks a push; a same-cycle pop does not free the slot early.
  assign push      = !rst && gnt_any && (count < FULL_CNT);
  assign pop       = !rst && out_valid && out_ready;
  assign in_ready  = push ? (4'b0001 << gnt_idx) : 4'b0000;

`ifdef LINK_PARITY_EN
  assign wr_entry = {^lane_data[gnt_idx], gnt_idx, lane_data[gnt_idx]};
`else
  assign wr_entry = {gnt_idx, lane_data[gnt_idx]};
`endif

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr     <= 2'd0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rr     <= gnt_idx + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs forced to zero while empty so stale entries never leak.
  assign head     = out_valid ? mem[rd_ptr] : '0;
  assign out_data = head[WIDTH-1:0];
  assign out_src  = head[WIDTH +: 2];
`ifdef LINK_PARITY_EN
  assign out_parity = head[WIDTH+2];
`endif

endmodule

// File: tb/tb_p2p_link_arb.sv
// Directed self-checking bench for p2p_link_arb (DEPTH=4, WIDTH=8).
module tb_p2p_link_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
`ifdef LINK_PARITY_EN
  logic        out_parity;
`endif

  int passed = 0;
  int total  = 0;

  p2p_link_arb #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
`ifdef LINK_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change just after negedge; checks run 1 time unit later, far from posedge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    // Reset held two cycles with all sources requesting
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      chk("rst_in_ready", in_ready, 4'b0000);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
    end
`ifdef LINK_PARITY_EN
    chk("rst_parity", out_parity, 0);
`endif

    // Single source 2, empty FIFO with out_ready high
    step(); rst = 1'b0; in_valid = 4'b0100; in_data = {8'h00, 8'hA5, 8'h00, 8'h00}; out_ready = 1'b1; #1;
    chk("single_in_ready", in_ready, 4'b0100);
    chk("single_empty_valid", out_valid, 0);
    step(); in_valid = 4'b0000; #1;
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 8'hA5);
    chk("single_out_src", out_src, 2);
    chk("single_count1", count, 1);
    chk("single_no_ready", in_ready, 0);
    step(); #1;
    chk("single_count0", count, 0);
    chk("single_drained", out_valid, 0);

    // Source 3 alone moves rr to 0
    in_valid = 4'b1000; in_data = {8'h33, 8'h00, 8'h00, 8'h00}; #1;
    chk("src3_in_ready", in_ready, 4'b1000);

    // Fairness: all valid, streaming at one push and one pop per cycle
    step(); in_valid = 4'hF; in_data = {8'h13, 8'h12, 8'h11, 8'h10}; #1;
    chk("fair_head_src3", out_src, 3);
    chk("fair_head_data33", out_data, 8'h33);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin step(); #1; end
      chk("fair_grant", in_ready, 32'd1 << (k % 4));
      chk("fair_count", count, 1);
      if (k > 0) begin
        chk("fair_out_src", out_src, (k - 1) % 4);
        chk("fair_out_data", out_data, 8'h10 + (k - 1) % 4);
      end
    end
    step(); in_valid = 4'b0000; #1;
    chk("fair_tail_src", out_src, 1);
    chk("fair_tail_data", out_data, 8'h11);
    step(); #1;
    chk("fair_drain", count, 0);

    // Full: rr=2, grants 2,3,0,1 then blocked
    out_ready = 1'b0; in_valid = 4'hF; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin step(); #1; end
      chk("fill_grant", in_ready, 32'd1 << ((2 + k) % 4));
      chk("fill_count", count, k);
    end
    step(); #1;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_head_src", out_src, 2);
    chk("full_head_data", out_data, 8'h12);
    step(); #1;
    chk("full_hold_count", count, 4);
    chk("full_hold_data", out_data, 8'h12);
    out_ready = 1'b1; #1;
    chk("full_pop_no_push", in_ready, 0);
    step(); out_ready = 1'b0; #1;
    chk("after_pop_count", count, 3);
    chk("after_pop_src", out_src, 3);
    chk("after_pop_data", out_data, 8'h13);
    chk("push_resumes", in_ready, 4'b0100);
    step(); in_valid = 4'b0000; #1;
    chk("refull_count", count, 4);

    // Reset mid-stream at count=3
    out_ready = 1'b1;
    step(); out_ready = 1'b0; #1;
    chk("mid_count3", count, 3);
    rst = 1'b1; in_valid = 4'hF; #1;
    chk("mid_rst_in_ready", in_ready, 0);
    step(); rst = 1'b0; in_valid = 4'b0001; in_data = {8'h00, 8'h00, 8'h00, 8'h5A}; #1;
    chk("mid_count0", count, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_rr_reset", in_ready, 4'b0001);
    step(); in_valid = 4'b0000; #1;
    chk("mid_new_data", out_data, 8'h5A);
    chk("mid_new_src", out_src, 0);
    chk("mid_new_count", count, 1);
    out_ready = 1'b1;
    step(); out_ready = 1'b0; #1;
    chk("mid_drain", count, 0);

`ifdef LINK_PARITY_EN
    in_valid = 4'b0010; in_data = {8'h00, 8'h00, 8'h07, 8'h00};
    step(); in_valid = 4'b0100; in_data = {8'h00, 8'h03, 8'h00, 8'h00};
    step(); in_valid = 4'b0000; #1;
    chk("par_data07", out_data, 8'h07);
    chk("par_one", out_parity, 1);
    out_ready = 1'b1;
    step(); out_ready = 1'b0; #1;
    chk("par_data03", out_data, 8'h03);
    chk("par_zero", out_parity, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
